// File: rtl/melody_seq_if.sv
// melody_seq_if: bundles the note-table write port, the tour-control
// handshake (go/stop/play_len/loop) and the buzzer/status outputs of
// melody_seq.
//   master : the controller side (drives writes and go/stop, reads status)
//   slave  : the melody_seq side
// Parameters must match the melody_seq instance the interface is bound to.
interface melody_seq_if #(
  parameter int NUM_NOTES = 8,
  parameter int PER_W     = 15,
  parameter int DUR_W     = 24
);
  localparam int IW = $clog2(NUM_NOTES);
  localparam int LW = $clog2(NUM_NOTES + 1);

  // note table write port
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [PER_W-1:0] wr_period;   // 0 = rest
  logic [DUR_W-1:0] wr_dur;
  // playback control
  logic             go;
  logic [LW-1:0]    play_len;
  logic             loop;
  logic             stop;
  // status and buzzer drive
  logic             busy;
  logic             done;
  logic [IW-1:0]    note_idx;
  logic             piezo;
  logic             piezo_n;

  modport master (
    output wr_en, wr_addr, wr_period, wr_dur, go, play_len, loop, stop,
    input  busy, done, note_idx, piezo, piezo_n
  );

  modport slave (
    input  wr_en, wr_addr, wr_period, wr_dur, go, play_len, loop, stop,
    output busy, done, note_idx, piezo, piezo_n
  );
endinterface

// File: rtl/melody_seq.sv
// melody_seq: programmable piezo tune player.
// Plays play_len notes (clamped to NUM_NOTES) from an internal table of
// {period, duration} entries, optionally looping, until completion or stop.
// Each note takes one LOAD cycle (latches the entry) followed by PLAY cycles
// until the duration counter reaches the note's duration.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   bus      : melody_seq_if slave modport (table writes, go/stop/play_len/
//              loop in; busy, done, note_idx, piezo, piezo_n out)
module melody_seq #(
  parameter int NUM_NOTES = 8,
  parameter int PER_W     = 15,
  parameter int DUR_W     = 24,
  parameter int FAST_SIM  = 1
) (
  input  logic        clk,
  input  logic        rst,
  melody_seq_if.slave bus
);
  localparam int IW = $clog2(NUM_NOTES);
  localparam int LW = $clog2(NUM_NOTES + 1);

  localparam logic [DUR_W:0]   DUR_INC = (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);
  localparam logic [LW-1:0]    LEN_MAX = LW'(NUM_NOTES);
  localparam logic [LW-1:0]    LEN_ONE = LW'(1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;

  state_e           state_q,   state_d;
  logic [IW-1:0]    idx_q,     idx_d;
  logic [LW-1:0]    len_q,     len_d;
  logic             loop_q,    loop_d;
  logic [PER_W-1:0] cur_per_q, cur_per_d;
  logic [DUR_W-1:0] cur_dur_q, cur_dur_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [DUR_W:0]   dur_cnt_q, dur_cnt_d;   // one spare bit so it never wraps
  logic             done_q,    done_d;

  logic [PER_W-1:0] tbl_per_q [NUM_NOTES];
  logic [DUR_W-1:0] tbl_dur_q [NUM_NOTES];

  logic last_note;
  logic note_end;
  logic tone_on;
  logic high_phase;

  // NOTE: the table is reset like any other register: after reset every
  // entry must read back as a {0,0} rest, so it cannot be left as plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        tbl_per_q[i] <= '0;
        tbl_dur_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      tbl_per_q[bus.wr_addr] <= bus.wr_period;
      tbl_dur_q[bus.wr_addr] <= bus.wr_dur;
    end
  end

  assign last_note = (LW'(idx_q) == (len_q - LEN_ONE));
  assign note_end  = (dur_cnt_q >= {1'b0, cur_dur_q});

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    loop_d    = loop_q;
    cur_per_d = cur_per_q;
    cur_dur_d = cur_dur_q;
    per_cnt_d = per_cnt_q;
    dur_cnt_d = dur_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.go && !bus.stop && (bus.play_len != '0)) begin
          len_d   = (bus.play_len > LEN_MAX) ? LEN_MAX : bus.play_len;
          loop_d  = bus.loop;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // The sounding note is frozen here; later table writes to this entry
        // only matter at its next LOAD.
        cur_per_d = tbl_per_q[idx_q];
        cur_dur_d = tbl_dur_q[idx_q];
        per_cnt_d = '0;
        dur_cnt_d = '0;
        state_d   = bus.stop ? S_IDLE : S_PLAY;
      end

      S_PLAY: begin
        if ((cur_per_q == '0) || (per_cnt_q == cur_per_q - PER_ONE)) begin
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + PER_ONE;
        end
        dur_cnt_d = dur_cnt_q + DUR_INC;

        // stop has priority over the end-of-note decision
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (note_end) begin
          if (!last_note) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      cur_per_q <= '0;
      cur_dur_q <= '0;
      per_cnt_q <= '0;
      dur_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      cur_per_q <= cur_per_d;
      cur_dur_q <= cur_dur_d;
      per_cnt_q <= per_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      done_q    <= done_d;
    end
  end

  // Outputs decode registers only. A rest (period 0) turns the driver off;
  // period 1 gives an empty high phase, so piezo_n stays on.
  assign tone_on    = (state_q == S_PLAY) && (cur_per_q != '0);
  assign high_phase = (per_cnt_q < (cur_per_q >> 1));

  assign bus.piezo    = tone_on && high_phase;
  assign bus.piezo_n  = tone_on && !high_phase;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = idx_q;
endmodule
